// File: rtl/flipflop_bank_out.sv
// Bank of independent set/clear/toggle output flip-flops with optional edge detection,
// configurable set/clear priority and a retriggerable auto-clear timeout per channel.
module flipflop_bank_out #(
  parameter int                  CHANNELS   = 8,
  parameter logic [CHANNELS-1:0] DEFAULT    = '0,
  parameter bit                  EDGE       = 1'b0,
  parameter bit                  CLEAR_WINS = 1'b1,
  parameter int                  TIMEOUT    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] set,
  input  logic [CHANNELS-1:0] clear,
  input  logic [CHANNELS-1:0] toggle,
  output logic [CHANNELS-1:0] bits,
  output logic [CHANNELS-1:0] expired
);

  logic [CHANNELS-1:0] ev_set, ev_clr, ev_tog;
  logic [CHANNELS-1:0] do_set, do_clr, do_tog;

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  if (EDGE) begin : g_edge
    logic [CHANNELS-1:0] set_h, clr_h, tog_h;

    // History tracks the inputs on every edge, reset included, so a request held
    // high through reset never looks like a fresh rising edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
      set_h <= set;
      clr_h <= clear;
      tog_h <= toggle;
    end

    assign ev_set = set    & ~set_h;
    assign ev_clr = clear  & ~clr_h;
    assign ev_tog = toggle & ~tog_h;
  end else begin : g_level
    assign ev_set = set;
    assign ev_clr = clear;
    assign ev_tog = toggle;
  end

  // Set/clear conflict resolution; either one masks a simultaneous toggle.
  if (CLEAR_WINS) begin : g_clear_wins
    assign do_set = ev_set & ~ev_clr;
    assign do_clr = ev_clr;
  end else begin : g_set_wins
    assign do_set = ev_set;
    assign do_clr = ev_clr & ~ev_set;
  end
  assign do_tog = ev_tog & ~ev_set & ~ev_clr;

  // ---------------------------------------------------------------------------
  // Output state
  // ---------------------------------------------------------------------------
  if (TIMEOUT == 0) begin : g_latch
    always_ff @(posedge clk) begin
      if (rst) begin
        bits <= DEFAULT;
      end else begin
        bits <= ((bits & ~do_clr) | do_set) ^ do_tog;
      end
    end

    assign expired = '0;
  end else begin : g_timed
    localparam int              TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int              RELOAD_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0]   RELOAD   = TW'(RELOAD_I);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic          bit_q, bit_n;
      logic          exp_q, exp_n;
      logic [TW-1:0] tmr_q, tmr_n;

      // NOTE: every variable gets a default before the decision chain so no
      // path leaves one unassigned, which would infer a latch.
      always_comb begin
        bit_n = bit_q;
        tmr_n = tmr_q;
        exp_n = 1'b0;
        if (do_set[i]) begin
          bit_n = 1'b1;
          tmr_n = RELOAD;
        end else if (do_clr[i]) begin
          bit_n = 1'b0;
          tmr_n = '0;
        end else if (do_tog[i]) begin
          bit_n = ~bit_q;
          tmr_n = bit_q ? '0 : RELOAD;
        end else if (bit_q) begin
          // Timer reaching zero while high marks the last of TIMEOUT cycles.
          if (tmr_q == '0) begin
            bit_n = 1'b0;
            exp_n = 1'b1;
          end else begin
            tmr_n = tmr_q - TW'(1);
          end
        end
      end

      // A channel defaulting high is armed during reset, so it times out
      // TIMEOUT cycles after release like any other set.
      always_ff @(posedge clk) begin
        if (rst) begin
          bit_q <= DEFAULT[i];
          tmr_q <= DEFAULT[i] ? RELOAD : '0;
          exp_q <= 1'b0;
        end else begin
          bit_q <= bit_n;
          tmr_q <= tmr_n;
          exp_q <= exp_n;
        end
      end

      assign bits[i]    = bit_q;
      assign expired[i] = exp_q;
    end
  end

endmodule
